// File: rtl/adam_axil_apb_bridge.sv
// AXI-Lite slave to APB requester, one transaction in flight; ACCESS timeout under ADAM_AXIL_APB_BRIDGE_TIMEOUT_EN.
// Latency: handshake N, SETUP N+1, ACCESS N+2, B/R valid N+3, plus one cycle per APB wait state.
// Backpressure: AW/W/AR ready only in IDLE with no pause request; B/R valid held until accepted.
module adam_axil_apb_bridge #(
    parameter int  ADDR_WIDTH     = 32,
    parameter int  DATA_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pause_req,
    output logic                  pause_ack,
    input  logic [ADDR_WIDTH-1:0] axil_aw_addr,
    input  logic [2:0]            axil_aw_prot,
    input  logic                  axil_aw_vld,
    output logic                  axil_aw_rdy,
    input  logic [DATA_WIDTH-1:0] axil_w_dat,
    input  logic [STRB_WIDTH-1:0] axil_w_strb,
    input  logic                  axil_w_vld,
    output logic                  axil_w_rdy,
    output logic [1:0]            axil_b_resp,
    output logic                  axil_b_vld,
    input  logic                  axil_b_rdy,
    input  logic [ADDR_WIDTH-1:0] axil_ar_addr,
    input  logic [2:0]            axil_ar_prot,
    input  logic                  axil_ar_vld,
    output logic                  axil_ar_rdy,
    output logic [DATA_WIDTH-1:0] axil_r_dat,
    output logic [1:0]            axil_r_resp,
    output logic                  axil_r_vld,
    input  logic                  axil_r_rdy,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [2:0]            pprot,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP_B, RESP_R, PAUSED} state_t;

    state_t     state;
    logic       last_wr;
    logic       wr_elig;
    logic       grant_wr;
    logic       grant_rd;
    logic       timed_out;
    logic       access_done;
    logic [1:0] resp_code;

    // A contested grant goes to whichever side did not win last time.
    assign wr_elig  = axil_aw_vld && axil_w_vld;
    assign grant_wr = wr_elig && (!axil_ar_vld || !last_wr);
    assign grant_rd = axil_ar_vld && !grant_wr;

    assign axil_aw_rdy = (state == IDLE) && !pause_req && grant_wr;
    assign axil_w_rdy  = axil_aw_rdy;
    assign axil_ar_rdy = (state == IDLE) && !pause_req && grant_rd;

    assign psel    = (state == SETUP) || (state == ACCESS);
    assign penable = (state == ACCESS);

`ifdef ADAM_AXIL_APB_BRIDGE_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] access_cnt;

    // Counts completed ACCESS cycles; zero whenever a new transaction starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            access_cnt <= '0;
        end else if (state != ACCESS) begin
            access_cnt <= '0;
        end else begin
            access_cnt <= access_cnt + CNT_W'(1);
        end
    end

    assign timed_out = (state == ACCESS) && !pready && (access_cnt == CNT_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timed_out      = 1'b0;
`endif

    assign access_done = (state == ACCESS) && (pready || timed_out);
    assign resp_code   = (timed_out || pslverr) ? 2'b10 : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_wr     <= 1'b0;
            pause_ack   <= 1'b0;
            paddr       <= '0;
            pprot       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            axil_b_vld  <= 1'b0;
            axil_b_resp <= '0;
            axil_r_vld  <= 1'b0;
            axil_r_resp <= '0;
            axil_r_dat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pause_req) begin
                        state     <= PAUSED;
                        pause_ack <= 1'b1;
                    end else if (grant_wr) begin
                        state   <= SETUP;
                        last_wr <= 1'b1;
                        paddr   <= axil_aw_addr;
                        pprot   <= axil_aw_prot;
                        pwrite  <= 1'b1;
                        pwdata  <= axil_w_dat;
                        pstrb   <= axil_w_strb;
                    end else if (grant_rd) begin
                        state   <= SETUP;
                        last_wr <= 1'b0;
                        paddr   <= axil_ar_addr;
                        pprot   <= axil_ar_prot;
                        pwrite  <= 1'b0;
                        pstrb   <= '0;
                    end
                end
                SETUP: state <= ACCESS;
                ACCESS: begin
                    if (access_done) begin
                        if (pwrite) begin
                            state       <= RESP_B;
                            axil_b_vld  <= 1'b1;
                            axil_b_resp <= resp_code;
                        end else begin
                            state       <= RESP_R;
                            axil_r_vld  <= 1'b1;
                            axil_r_resp <= resp_code;
                            axil_r_dat  <= timed_out ? '0 : prdata;
                        end
                    end
                end
                RESP_B: begin
                    if (axil_b_rdy) begin
                        state      <= IDLE;
                        axil_b_vld <= 1'b0;
                    end
                end
                RESP_R: begin
                    if (axil_r_rdy) begin
                        state      <= IDLE;
                        axil_r_vld <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (!pause_req) begin
                        state     <= IDLE;
                        pause_ack <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adam_axil_apb_bridge.sv
// Bench for adam_axil_apb_bridge: directed vectors, pause/reset sequences and a random mix against a grant/latency model.
module tb_adam_axil_apb_bridge;

    logic        clk, rst, pause_req, pause_ack;
    logic [31:0] axil_aw_addr, axil_w_dat, axil_ar_addr, axil_r_dat;
    logic [2:0]  axil_aw_prot, axil_ar_prot;
    logic [3:0]  axil_w_strb;
    logic        axil_aw_vld, axil_aw_rdy, axil_w_vld, axil_w_rdy;
    logic [1:0]  axil_b_resp, axil_r_resp;
    logic        axil_b_vld, axil_b_rdy, axil_ar_vld, axil_ar_rdy, axil_r_vld, axil_r_rdy;
    logic [31:0] paddr, pwdata, prdata;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;
    logic        psel, penable, pwrite, pready, pslverr;

    adam_axil_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
        .axil_aw_addr(axil_aw_addr), .axil_aw_prot(axil_aw_prot), .axil_aw_vld(axil_aw_vld), .axil_aw_rdy(axil_aw_rdy),
        .axil_w_dat(axil_w_dat), .axil_w_strb(axil_w_strb), .axil_w_vld(axil_w_vld), .axil_w_rdy(axil_w_rdy),
        .axil_b_resp(axil_b_resp), .axil_b_vld(axil_b_vld), .axil_b_rdy(axil_b_rdy),
        .axil_ar_addr(axil_ar_addr), .axil_ar_prot(axil_ar_prot), .axil_ar_vld(axil_ar_vld), .axil_ar_rdy(axil_ar_rdy),
        .axil_r_dat(axil_r_dat), .axil_r_resp(axil_r_resp), .axil_r_vld(axil_r_vld), .axil_r_rdy(axil_r_rdy),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected APB request and completer behaviour for the transaction in flight.
    bit          mon_en = 1'b0;
    bit          exp_write;
    logic [31:0] exp_addr, exp_data;
    logic [3:0]  exp_strb;
    logic [2:0]  exp_prot;
    int          wait_n = 0;
    int          acc_cnt = 0;
    bit          model_last_wr = 1'b0;

    initial begin
        pready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (psel && mon_en) begin
                chk("apb_paddr", paddr, exp_addr);
                chk("apb_pwrite", pwrite, exp_write);
                chk("apb_pprot", pprot, exp_prot);
                chk("apb_pstrb", pstrb, exp_strb);
                if (exp_write) chk("apb_pwdata", pwdata, exp_data);
            end
            if (penable) begin
                pready = (acc_cnt == wait_n);
                acc_cnt++;
            end else begin
                pready  = 1'b0;
                acc_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    task automatic put_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        axil_aw_addr = a; axil_w_dat = d; axil_w_strb = s; axil_aw_prot = p;
        axil_aw_vld = 1'b1; axil_w_vld = 1'b1;
    endtask

    task automatic put_rd(input logic [31:0] a, input logic [2:0] p);
        axil_ar_addr = a; axil_ar_prot = p; axil_ar_vld = 1'b1;
    endtask

    function automatic bit pred_grant();
        bit wr_ok = axil_aw_vld && axil_w_vld;
        return wr_ok && (!axil_ar_vld || !model_last_wr);
    endfunction

    // Runs one transaction whose valids are already on the bus; called at 1 time unit after a rising edge in IDLE.
    task automatic run_one(input bit gwr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [2:0] prot, input int wn, input bit err, input logic [31:0] rdv,
                           input logic [1:0] eresp, input logic [31:0] erdata, input int elat, input int rdly);
        int cyc;
        wait_n = wn; pslverr = err; prdata = rdv;
        exp_write = gwr; exp_addr = addr; exp_data = data; exp_strb = gwr ? strb : 4'h0; exp_prot = prot;
        mon_en = 1'b1;
        #1;
        chk("aw_rdy", axil_aw_rdy, gwr);
        chk("w_rdy", axil_w_rdy, gwr);
        chk("ar_rdy", axil_ar_rdy, !gwr);
        @(posedge clk); #1;
        if (gwr) begin axil_aw_vld = 1'b0; axil_w_vld = 1'b0; end
        else axil_ar_vld = 1'b0;
        model_last_wr = gwr;
        chk("setup_phase", {psel, penable}, 2'b10);
        cyc = 1;
        while (!(axil_b_vld || axil_r_vld) && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) chk("access_phase", {psel, penable}, 2'b11);
        end
        chk("resp_latency", cyc, elat);
        for (int d = 0; d <= rdly; d++) begin
            if (d == rdly) begin
                if (gwr) axil_b_rdy = 1'b1; else axil_r_rdy = 1'b1;
                #1;
                chk("no_accept_in_resp", {axil_aw_rdy, axil_ar_rdy}, 2'b00);
            end
            chk("resp_valids", {axil_b_vld, axil_r_vld}, gwr ? 2'b10 : 2'b01);
            if (gwr) chk("b_resp", axil_b_resp, eresp);
            else begin
                chk("r_resp", axil_r_resp, eresp);
                chk("r_dat", axil_r_dat, erdata);
            end
            @(posedge clk); #1;
        end
        axil_b_rdy = 1'b0; axil_r_rdy = 1'b0;
        chk("resp_done", {axil_b_vld, axil_r_vld}, 2'b00);
        mon_en = 1'b0;
    endtask

    task automatic next_txn(input bit allow_new);
        bit          gw, er;
        int          wn;
        logic [31:0] rdv;
        if (allow_new) begin
            if (!axil_aw_vld && $urandom_range(0, 2) != 0)
                put_wr($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), 3'($urandom));
            if (!axil_ar_vld && (!axil_aw_vld || $urandom_range(0, 1) == 1))
                put_rd($urandom & 32'hFFFF_FFFC, 3'($urandom));
        end
        gw  = pred_grant();
        wn  = $urandom_range(0, 3);
        er  = 1'($urandom_range(0, 1));
        rdv = $urandom;
        if (gw) run_one(1'b1, axil_aw_addr, axil_w_dat, axil_w_strb, axil_aw_prot, wn, er, rdv,
                        er ? 2'b10 : 2'b00, 32'h0, 3 + wn, $urandom_range(0, 2));
        else    run_one(1'b0, axil_ar_addr, 32'h0, 4'h0, axil_ar_prot, wn, er, rdv,
                        er ? 2'b10 : 2'b00, rdv, 3 + wn, $urandom_range(0, 2));
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          wn;
        bit          err;
        logic [31:0] rdv;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc;
        vecs[0] = '{1'b1, 32'h0001_0010, 32'hCAFE_F00D, 4'b0011, 3'd0, 0, 1'b0, 32'h0,         2'b00, 32'h0,         3};
        vecs[1] = '{1'b0, 32'h0001_0020, 32'h0,         4'b0000, 3'd2, 3, 1'b0, 32'h1234_5678, 2'b00, 32'h1234_5678, 6};
        vecs[2] = '{1'b1, 32'h0001_0030, 32'hA5A5_5A5A, 4'b1111, 3'd1, 0, 1'b1, 32'h0,         2'b10, 32'h0,         3};
        vecs[3] = '{1'b0, 32'h0001_0034, 32'h0,         4'b0000, 3'd0, 0, 1'b0, 32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D, 3};
        vecs[4] = '{1'b0, 32'h0001_003C, 32'h0,         4'b0000, 3'd4, 1, 1'b1, 32'hFFFF_0000, 2'b10, 32'hFFFF_0000, 4};
        vecs[5] = '{1'b1, 32'h0001_0040, 32'h0000_0001, 4'b1000, 3'd7, 2, 1'b0, 32'h0,         2'b00, 32'h0,         5};

        rst = 1'b1; pause_req = 1'b0;
        axil_aw_addr = '0; axil_aw_prot = '0; axil_aw_vld = 1'b0;
        axil_w_dat = '0; axil_w_strb = '0; axil_w_vld = 1'b0; axil_b_rdy = 1'b0;
        axil_ar_addr = '0; axil_ar_prot = '0; axil_ar_vld = 1'b0; axil_r_rdy = 1'b0;
        prdata = '0; pslverr = 1'b0;

        @(posedge clk); #1;
        chk("rst_apb_ctrl", {psel, penable, pwrite}, 3'b000);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pstrb_pprot", {pstrb, pprot}, 7'h0);
        chk("rst_valids", {axil_b_vld, axil_r_vld}, 2'b00);
        chk("rst_readys", {axil_aw_rdy, axil_w_rdy, axil_ar_rdy}, 3'b000);
        chk("rst_resps", {axil_b_resp, axil_r_resp}, 4'h0);
        chk("rst_r_dat", axil_r_dat, 32'h0);
        chk("rst_pause_ack", pause_ack, 1'b0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Contested grants: write first after reset, then strict alternation.
        put_wr(32'h0000_1000, 32'hA000_0000, 4'hF, 3'd0);
        put_rd(32'h0000_2000, 3'd1);
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) begin
                run_one(1'b1, axil_aw_addr, axil_w_dat, axil_w_strb, axil_aw_prot, 0, 1'b0, 32'h0, 2'b00, 32'h0, 3, 0);
                if (k < 18) put_wr(32'h0000_1000 + 32'(k * 4), 32'hA000_0000 + 32'(k), 4'hF, 3'(k));
            end else begin
                run_one(1'b0, axil_ar_addr, 32'h0, 4'h0, axil_ar_prot, 1, 1'b0, 32'h5000 + 32'(k), 2'b00,
                        32'h5000 + 32'(k), 4, 0);
                if (k < 18) put_rd(32'h0000_2000 + 32'(k * 4), 3'(k));
            end
        end

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_wr) put_wr(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].prot);
            else put_rd(vecs[i].addr, vecs[i].prot);
            run_one(vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].prot, vecs[i].wn, vecs[i].err,
                    vecs[i].rdv, vecs[i].exp_resp, vecs[i].exp_rdata, vecs[i].exp_lat, i % 3);
        end

        // Pause raised mid-ACCESS: the write finishes, then the held read waits until the pause is released.
        put_wr(32'h0001_0050, 32'h7777_0001, 4'hF, 3'd0);
        wait_n = 2; pslverr = 1'b0;
        exp_write = 1'b1; exp_addr = 32'h0001_0050; exp_data = 32'h7777_0001; exp_strb = 4'hF; exp_prot = 3'd0;
        mon_en = 1'b1;
        #1 chk("pause_aw_rdy", axil_aw_rdy, 1'b1);
        @(posedge clk); #1;
        axil_aw_vld = 1'b0; axil_w_vld = 1'b0; model_last_wr = 1'b1;
        put_rd(32'h0001_0054, 3'd0);
        chk("pause_ar_blocked_setup", axil_ar_rdy, 1'b0);
        @(posedge clk); #1;
        pause_req = 1'b1;
        chk("pause_in_access", {psel, penable}, 2'b11);
        cyc = 2;
        while (!axil_b_vld && cyc < 60) begin @(posedge clk); #1; cyc++; end
        chk("pause_latency", cyc, 5);
        chk("pause_bresp", axil_b_resp, 2'b00);
        chk("pause_ack_busy", pause_ack, 1'b0);
        axil_b_rdy = 1'b1;
        #1 chk("pause_ar_blocked_resp", axil_ar_rdy, 1'b0);
        @(posedge clk); #1;
        axil_b_rdy = 1'b0; mon_en = 1'b0;
        chk("pause_idle_blocked", axil_ar_rdy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("pause_ack_high", pause_ack, 1'b1);
            chk("pause_ar_held", axil_ar_rdy, 1'b0);
        end
        pause_req = 1'b0;
        @(posedge clk); #1;
        chk("pause_ack_low", pause_ack, 1'b0);
        run_one(1'b0, 32'h0001_0054, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h600D_CAFE, 2'b00, 32'h600D_CAFE, 3, 1);

        for (int i = 0; i < 40; i++) next_txn(1'b1);
        for (int k = 0; k < 2 && (axil_aw_vld || axil_ar_vld); k++) next_txn(1'b0);

`ifdef ADAM_AXIL_APB_BRIDGE_TIMEOUT_EN
        put_rd(32'h0001_0070, 3'd0);
        run_one(1'b0, 32'h0001_0070, 32'h0, 4'h0, 3'd0, 1000, 1'b0, 32'hDEAD_BEEF, 2'b10, 32'h0, 10, 0);
`endif

        // Asynchronous reset in ACCESS drops the read with no response.
        put_rd(32'h0001_0060, 3'd0);
        wait_n = 1000; mon_en = 1'b0;
        #1 chk("rst_mid_ar_rdy", axil_ar_rdy, 1'b1);
        @(posedge clk); #1;
        axil_ar_vld = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_access", {psel, penable}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_apb_idle", {psel, penable}, 2'b00);
        chk("rst_mid_paddr", paddr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; model_last_wr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("rst_mid_no_resp", {axil_b_vld, axil_r_vld, psel}, 3'b000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
